uart_receiver: RTL and testbench

Serial-to-parallel UART receiver that pairs with the transmitter: recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from the `rx` line using a 16× oversampled, mid-bit sampling scheme. It runs in the system clock domain. It owns its own oversample tick generation, so it does not depend on the transmitter's `baud_clk`. It delivers each good byte with a one-cycle `data_valid` strobe and flags bad stop bits.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_tick_gen.sv | 27 ++
 rtl/uart_receiver.sv | 137 +++++++++++++
 tb/tb_uart_receiver.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default oversample ratio
// and the baud divider calculation used by both the transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int unsigned UART_OVERSAMPLE = 16;

  function automatic int unsigned uart_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick divider: one-cycle tick every DIV clocks; clear re-phases the
// count so the first tick lands DIV clocks after the clear.
module uart_rx_tick_gen #(
  parameter int unsigned DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = (clear || tick) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop input synchronizer, oversampled mid-bit sampling,
// one-cycle data_valid / frame_err strobes and a BREAK hold on a stuck-low line.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned DIV = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] SCNT_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(OVERSAMPLE - 1);

  uart_rx_state_t state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q, data_d;
  logic          data_valid_q, data_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          tick, tick_clear;

  uart_rx_tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(tick_clear),
    .tick (tick)
  );

  always_comb begin
    state_d      = state_q;
    scnt_d       = scnt_q;
    bcnt_d       = bcnt_q;
    shreg_d      = shreg_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    tick_clear   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d    = START;
          scnt_d     = '0;
          tick_clear = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (scnt_q == SCNT_HALF) begin
            scnt_d  = '0;
            bcnt_d  = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (scnt_q == SCNT_LAST) begin
            shreg_d = {rx_s_q, shreg_q[7:1]};
            scnt_d  = '0;
            if (bcnt_q == 3'd7) state_d = STOP;
            else                bcnt_d  = bcnt_q + 3'd1;
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (scnt_q == SCNT_LAST) begin
            scnt_d = '0;
            if (rx_s_q) begin
              data_d       = shreg_q;
              data_valid_d = 1'b1;
              state_d      = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = BREAK;
            end
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
      end
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= IDLE;
      scnt_q       <= '0;
      bcnt_q       <= '0;
      shreg_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      scnt_q       <= scnt_d;
      bcnt_q       <= bcnt_d;
      shreg_q      <= shreg_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at DIV=10 (160 clk per bit): directed
// corner sequences, a frame vector table and randomized frames vs. a line model.
module tb_uart_receiver;

  localparam int unsigned BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       rx_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  logic [7:0] rxq[$];
  time last_dv_t = 0;

  uart_receiver #(
    .CLK_FREQ  (1_600_000),
    .BAUD_RATE (10_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Pulse monitor; data_valid and frame_err must never coincide.
  always @(negedge clk) begin
    if (rst_n && (data_valid || frame_err)) begin
      n_cmp++;
      if (data_valid && frame_err) begin
        n_bad++;
        $display("FAIL pulse_overlap: got dv=1 fe=1, expected at most one");
      end
      if (data_valid) begin
        dv_cnt++;
        rxq.push_back(data);
        last_dv_t = $time;
      end
      if (frame_err) fe_cnt++;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Drive start bit and 8 data bits LSB-first; called on a negedge.
  task automatic send_bits(input logic [7:0] b, input int unsigned bclk);
    rx = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bclk) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int unsigned bclk);
    send_bits(b, bclk);
    if (stop_ok) begin
      rx = 1'b1;
      repeat (bclk) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (3 * bclk) @(negedge clk);
      rx = 1'b1;
      repeat (bclk) @(negedge clk);
    end
  endtask

  task automatic frame_check(input string tag, input int dv0, input int fe0,
                             input int exp_dv, input int exp_fe, input logic [7:0] exp_data);
    check({tag, " dv_pulses"}, dv_cnt - dv0, exp_dv);
    check({tag, " fe_pulses"}, fe_cnt - fe0, exp_fe);
    check({tag, " data"}, int'(data), int'(exp_data));
    check({tag, " busy"}, int'(rx_busy), 0);
  endtask

  typedef struct {
    logic [7:0]  din;
    bit          stop_ok;
    int unsigned bclk;
    int          exp_dv;
    int          exp_fe;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int dv0, fe0, base;
    logic [7:0] tamim[5];
    logic [7:0] model_data;
    logic [7:0] model_q[$];
    time t_fall;
    int lat;

    vecs[0] = '{8'h54, 1'b1, 160, 1, 0, 8'h54};
    vecs[1] = '{8'hA5, 1'b0, 160, 0, 1, 8'h54};
    vecs[2] = '{8'h3C, 1'b1, 160, 1, 0, 8'h3C};
    vecs[3] = '{8'h55, 1'b1, 155, 1, 0, 8'h55};
    vecs[4] = '{8'h00, 1'b1, 165, 1, 0, 8'h00};
    vecs[5] = '{8'hC3, 1'b0, 165, 0, 1, 8'h00};
    tamim = '{8'h54, 8'h41, 8'h4D, 8'h49, 8'h4D};

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    check("reset data", int'(data), 0);
    check("reset dv", int'(data_valid), 0);
    check("reset fe", int'(frame_err), 0);
    check("reset busy", int'(rx_busy), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single 0x54 frame with latency from falling edge to data_valid.
    dv0 = dv_cnt; fe0 = fe_cnt;
    t_fall = $time;
    send_frame(8'h54, 1'b1, BIT_CLKS);
    repeat (5) @(negedge clk);
    frame_check("single", dv0, fe0, 1, 0, 8'h54);
    lat = int'((last_dv_t - t_fall) / 10);
    check("latency_in_window", int'(lat >= 1521 && lat <= 1525), 1);

    // Back-to-back "TAMIM" with no idle gap.
    dv0 = dv_cnt; fe0 = fe_cnt; base = rxq.size();
    foreach (tamim[i]) send_frame(tamim[i], 1'b1, BIT_CLKS);
    repeat (5) @(negedge clk);
    frame_check("tamim", dv0, fe0, 5, 0, 8'h4D);
    for (int i = 0; i < 5; i++)
      check($sformatf("tamim byte%0d", i),
            (base + i < rxq.size()) ? int'(rxq[base + i]) : -1, int'(tamim[i]));

    // 40-clk low glitch while idle.
    dv0 = dv_cnt; fe0 = fe_cnt;
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    check("glitch busy_rise", int'(rx_busy), 1);
    repeat (60) @(negedge clk);
    frame_check("glitch", dv0, fe0, 0, 0, 8'h4D);

    // Low stop bit, held low: frame_err then BREAK until the line rises.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_bits(8'hA5, BIT_CLKS);
    rx = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("break fe_pulses", fe_cnt - fe0, 1);
    check("break busy_held", int'(rx_busy), 1);
    check("break data_kept", int'(data), 8'h4D);
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    frame_check("break", dv0, fe0, 0, 1, 8'h4D);
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'h3C, 1'b1, BIT_CLKS);
    repeat (5) @(negedge clk);
    frame_check("after_break", dv0, fe0, 1, 0, 8'h3C);

    // One-cycle reset in the middle of data bit 4 of 0xFF.
    dv0 = dv_cnt; fe0 = fe_cnt;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (4 * BIT_CLKS + 80) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset data", int'(data), 0);
    check("midreset dv", int'(data_valid), 0);
    check("midreset fe", int'(frame_err), 0);
    check("midreset busy", int'(rx_busy), 0);
    repeat (6 * BIT_CLKS) @(negedge clk);
    frame_check("midreset", dv0, fe0, 0, 0, 8'h00);
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'h81, 1'b1, BIT_CLKS);
    repeat (5) @(negedge clk);
    frame_check("after_reset", dv0, fe0, 1, 0, 8'h81);

    // Vector table, including +/-3% bit periods.
    foreach (vecs[i]) begin
      dv0 = dv_cnt; fe0 = fe_cnt;
      send_frame(vecs[i].din, vecs[i].stop_ok, vecs[i].bclk);
      repeat (20) @(negedge clk);
      frame_check($sformatf("vec%0d", i), dv0, fe0, vecs[i].exp_dv, vecs[i].exp_fe,
                  vecs[i].exp_data);
    end

    // Randomized frames: the line model keeps the last good byte.
    model_data = data;
    base = rxq.size();
    for (int n = 0; n < 16; n++) begin
      logic [7:0]  b;
      bit          ok;
      int unsigned bclk, gap;
      b    = 8'($urandom);
      ok   = ($urandom_range(0, 4) != 0);
      bclk = $urandom_range(155, 165);
      gap  = $urandom_range(0, 50);
      if (ok) begin
        model_data = b;
        model_q.push_back(b);
      end
      dv0 = dv_cnt; fe0 = fe_cnt;
      send_frame(b, ok, bclk);
      repeat (gap) @(negedge clk);
      frame_check($sformatf("rand%0d", n), dv0, fe0, ok ? 1 : 0, ok ? 0 : 1, model_data);
    end
    check("rand byte_count", rxq.size() - base, model_q.size());
    foreach (model_q[i])
      check($sformatf("rand order%0d", i),
            (base + i < rxq.size()) ? int'(rxq[base + i]) : -1, int'(model_q[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
